// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the control FSM and the multicycle ALU.
// The master drives the operation request; the ALU answers on the slave side.
interface alu_multicycle_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       ALUOp;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUOp, in1, in2,
        input  out, N, Z, C, V, busy, done
    );

    modport slave (
        input  start, ALUOp, in1, in2,
        output out, N, Z, C, V, busy, done
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ADD/SUB/OR/NAND plus an iterative one-bit-per-cycle
// shifter, with registered result/flags and a start/busy/done handshake.
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    alu_multicycle_if.slave  bus
);
    localparam int S = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_OR    = 3'b010;
    localparam logic [2:0] OP_NAND  = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [S-1:0]     cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   add_r;
    logic [WIDTH:0]   sub_r;
    logic             add_v;
    logic             sub_v;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic [S-1:0]     sh_amt;

    logic             fin;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    // Extra top bit of the sums is the carry; for SUB it is the no-borrow flag.
    assign add_r = {1'b0, bus.in1} + {1'b0, bus.in2};
    assign sub_r = {1'b0, bus.in1} + {1'b0, ~bus.in2} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                   (add_r[WIDTH-1] != bus.in1[WIDTH-1]);
    assign sub_v = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                   (sub_r[WIDTH-1] != bus.in1[WIDTH-1]);
    assign sh_amt = bus.in2[S-1:0];

    always_comb begin
        if (dir_q) begin
            sh_next = {1'b0, work_q[WIDTH-1:1]};
            sh_out  = work_q[0];
        end else begin
            sh_next = {work_q[WIDTH-2:0], 1'b0};
            sh_out  = work_q[WIDTH-1];
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        out_d   = out_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        done_d  = 1'b0;
        fin     = 1'b0;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.ALUOp)
                        OP_ADD: begin
                            fin   = 1'b1;
                            res   = add_r[WIDTH-1:0];
                            res_c = add_r[WIDTH];
                            res_v = add_v;
                        end
                        OP_SUB: begin
                            fin   = 1'b1;
                            res   = sub_r[WIDTH-1:0];
                            res_c = sub_r[WIDTH];
                            res_v = sub_v;
                        end
                        OP_OR: begin
                            fin = 1'b1;
                            res = bus.in1 | bus.in2;
                        end
                        OP_NAND: begin
                            fin = 1'b1;
                            res = ~(bus.in1 & bus.in2);
                        end
                        OP_SHIFT: begin
                            work_d = bus.in1;
                            cnt_d  = sh_amt;
                            dir_d  = bus.in2[WIDTH-1];
                            if (sh_amt == '0) begin
                                fin = 1'b1;
                                res = bus.in1;
                            end else begin
                                state_d = SHIFT;
                            end
                        end
                        default: begin
                            fin = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                work_d = sh_next;
                cnt_d  = cnt_q - S'(1);
                if (cnt_q == S'(1)) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                    res     = sh_next;
                    res_c   = sh_out;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            out_d  = res;
            n_d    = res[WIDTH-1];
            z_d    = (res == '0);
            c_d    = res_c;
            v_d    = res_v;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            out_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.N    = n_q;
    assign bus.Z    = z_q;
    assign bus.C    = c_q;
    assign bus.V    = v_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=8 and WIDTH=16, with hand-computed
// expectations checked by immediate assertions.
module tb_alu_multicycle;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    alu_multicycle_if #(.WIDTH(8))  bus8 ();
    alu_multicycle_if #(.WIDTH(16)) bus16 ();

    alu_multicycle #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8.slave));
    alu_multicycle #(.WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus8.start  = 1'b0; bus8.ALUOp  = 3'b000; bus8.in1  = '0; bus8.in2  = '0;
        bus16.start = 1'b0; bus16.ALUOp = 3'b000; bus16.in1 = '0; bus16.in2 = '0;

        // Reset state
        tick();
        tick();
        check("rst_out", 32'(bus8.out), 32'h00);
        check("rst_flags", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'h0);
        check("rst_busy_done", {30'd0, bus8.busy, bus8.done}, 32'h0);
        check("rst16_out", 32'(bus16.out), 32'h0000);
        reset = 1'b0;
        tick();

        // ADD signed overflow
        bus8.start = 1'b1; bus8.ALUOp = 3'b000; bus8.in1 = 8'h7F; bus8.in2 = 8'h01;
        tick();
        bus8.start = 1'b0;
        check("add_out", 32'(bus8.out), 32'h80);
        check("add_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b1001);
        check("add_done", 32'(bus8.done), 32'h1);
        tick();
        check("add_done_fall", 32'(bus8.done), 32'h0);

        // SUB equal, then back-to-back SUB with borrow
        bus8.start = 1'b1; bus8.ALUOp = 3'b001; bus8.in1 = 8'h05; bus8.in2 = 8'h05;
        tick();
        check("sub0_out", 32'(bus8.out), 32'h00);
        check("sub0_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b0110);
        check("sub0_done", 32'(bus8.done), 32'h1);
        bus8.in1 = 8'h03; bus8.in2 = 8'h05;
        tick();
        bus8.start = 1'b0;
        check("sub1_out", 32'(bus8.out), 32'hFE);
        check("sub1_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b1000);
        check("sub1_done", 32'(bus8.done), 32'h1);
        tick();
        check("sub_done_fall", 32'(bus8.done), 32'h0);

        // NAND, OR, then reserved op after a nonzero result
        bus8.start = 1'b1; bus8.ALUOp = 3'b011; bus8.in1 = 8'hFF; bus8.in2 = 8'hFF;
        tick();
        check("nand_out", 32'(bus8.out), 32'h00);
        check("nand_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b0100);
        bus8.ALUOp = 3'b010; bus8.in1 = 8'hA0; bus8.in2 = 8'h05;
        tick();
        check("or_out", 32'(bus8.out), 32'hA5);
        check("or_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b1000);
        bus8.ALUOp = 3'b110; bus8.in1 = 8'h12; bus8.in2 = 8'h34;
        tick();
        bus8.start = 1'b0;
        check("rsv_out", 32'(bus8.out), 32'h00);
        check("rsv_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b0100);
        check("rsv_done", 32'(bus8.done), 32'h1);
        tick();

        // Left shift 0x81 by 3
        bus8.start = 1'b1; bus8.ALUOp = 3'b100; bus8.in1 = 8'h81; bus8.in2 = 8'h03;
        tick();
        bus8.start = 1'b0;
        check("shl_k0_busy_done", {30'd0, bus8.busy, bus8.done}, 32'b10);
        tick();
        check("shl_k1_busy_done", {30'd0, bus8.busy, bus8.done}, 32'b10);
        tick();
        check("shl_k2_busy_done", {30'd0, bus8.busy, bus8.done}, 32'b10);
        tick();
        check("shl_k3_busy_done", {30'd0, bus8.busy, bus8.done}, 32'b01);
        check("shl_out", 32'(bus8.out), 32'h08);
        check("shl_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b0000);
        tick();

        // Right shift 0x81 by 1
        bus8.start = 1'b1; bus8.in1 = 8'h81; bus8.in2 = 8'h81;
        tick();
        bus8.start = 1'b0;
        check("shr_k0_busy", 32'(bus8.busy), 32'h1);
        tick();
        check("shr_out", 32'(bus8.out), 32'h40);
        check("shr_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b0010);
        check("shr_done", 32'(bus8.done), 32'h1);
        tick();

        // Shift amount 0 completes immediately
        bus8.start = 1'b1; bus8.in1 = 8'h81; bus8.in2 = 8'h00;
        tick();
        bus8.start = 1'b0;
        check("sh0_out", 32'(bus8.out), 32'h81);
        check("sh0_busy_done", {30'd0, bus8.busy, bus8.done}, 32'b01);
        check("sh0_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b1000);
        tick();

        // 7-step left shift of 0x03 with start pulses and operand churn meanwhile
        bus8.start = 1'b1; bus8.ALUOp = 3'b100; bus8.in1 = 8'h03; bus8.in2 = 8'h07;
        tick();
        for (int i = 1; i <= 7; i++) begin
            bus8.start = i[0];
            bus8.ALUOp = 3'(i);
            bus8.in1   = 8'(i * 37);
            bus8.in2   = 8'(255 - i);
            check("busy_ign_done", 32'(bus8.done), 32'h0);
            tick();
        end
        bus8.start = 1'b0;
        check("busy_ign_done_end", 32'(bus8.done), 32'h1);
        check("busy_ign_out", 32'(bus8.out), 32'h80);
        check("busy_ign_nzcv", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'b1010);
        tick();
        check("busy_ign_idle", {30'd0, bus8.busy, bus8.done}, 32'b00);
        check("busy_ign_hold", 32'(bus8.out), 32'h80);

        // Reset during step 3 of a 5-step shift aborts it
        bus8.start = 1'b1; bus8.ALUOp = 3'b100; bus8.in1 = 8'h01; bus8.in2 = 8'h05;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        check("abort_pre_busy", 32'(bus8.busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out", 32'(bus8.out), 32'h00);
        check("abort_flags", {28'd0, bus8.N, bus8.Z, bus8.C, bus8.V}, 32'h0);
        check("abort_busy_done", {30'd0, bus8.busy, bus8.done}, 32'b00);
        tick();
        tick();
        tick();
        check("abort_no_done", {30'd0, bus8.busy, bus8.done}, 32'b00);
        check("abort_out_hold", 32'(bus8.out), 32'h00);

        // WIDTH=16: ADD wraparound
        bus16.start = 1'b1; bus16.ALUOp = 3'b000; bus16.in1 = 16'hFFFF; bus16.in2 = 16'h0001;
        tick();
        bus16.start = 1'b0;
        check("add16_out", 32'(bus16.out), 32'h0000);
        check("add16_nzcv", {28'd0, bus16.N, bus16.Z, bus16.C, bus16.V}, 32'b0110);
        check("add16_done", 32'(bus16.done), 32'h1);
        tick();

        // WIDTH=16: left shift 0x8001 by 15 (maximum latency)
        bus16.start = 1'b1; bus16.ALUOp = 3'b100; bus16.in1 = 16'h8001; bus16.in2 = 16'h000F;
        tick();
        bus16.start = 1'b0;
        check("shl16_k0_busy", 32'(bus16.busy), 32'h1);
        for (int i = 1; i < 15; i++) tick();
        check("shl16_k14_busy_done", {30'd0, bus16.busy, bus16.done}, 32'b10);
        tick();
        check("shl16_busy_done", {30'd0, bus16.busy, bus16.done}, 32'b01);
        check("shl16_out", 32'(bus16.out), 32'h8000);
        check("shl16_nzcv", {28'd0, bus16.N, bus16.Z, bus16.C, bus16.V}, 32'b1000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
